// File: rtl/btb_predictor.sv
// ============================================================================
//  Module      : btb_predictor
//  Description : Direct-mapped BTB with 2-bit direction counters and an
//                invalidate sweep. Optional macro BTB_STATS_EN adds counters.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module btb_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  input  logic        upd_mispredict,
  input  logic        flush_req,
  output logic        busy
`ifdef BTB_STATS_EN
  ,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_mispred
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(ENTRIES - 1);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;
  logic             sweep_active;
  logic             upd_en;
  logic [1:0]       up_ctr;
  logic [1:0]       up_ctr_inc, up_ctr_dec;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[31:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[31:IDX_W+2];

  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  assign sweep_active = (state_q == ST_SWEEP);
  assign busy         = sweep_active;

  // A flush request starting in the same cycle wins over a pending update.
  assign upd_en = upd_valid && !sweep_active && !flush_req;

  assign pred_taken  = lk_hit && ctr_q[lk_idx][1] && !sweep_active;
  assign pred_target = lk_hit ? target_q[lk_idx] : 32'h0;

  assign up_ctr     = ctr_q[up_idx];
  assign up_ctr_inc = (up_ctr == 2'b11) ? 2'b11 : up_ctr + 2'b01;
  assign up_ctr_dec = (up_ctr == 2'b00) ? 2'b00 : up_ctr - 2'b01;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (flush_req) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end
      end
      ST_SWEEP: begin
        if (cnt_q == c_LAST_IDX) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (sweep_active) begin
      valid_q[cnt_q] <= 1'b0;
    end else if (upd_en && !up_hit && upd_taken) begin
      valid_q[up_idx] <= 1'b1;
    end
  end

  // Payload arrays carry no reset; valid gates every use of them.
  always_ff @(posedge clk) begin
    if (sweep_active) begin
      ctr_q[cnt_q] <= 2'b01;
    end else if (upd_en) begin
      if (up_hit) begin
        if (upd_taken) begin
          ctr_q[up_idx]    <= up_ctr_inc;
          target_q[up_idx] <= upd_target;
        end else begin
          ctr_q[up_idx] <= up_ctr_dec;
        end
      end else if (upd_taken) begin
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_target;
        ctr_q[up_idx]    <= 2'b10;
      end
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups_q, stat_hits_q, stat_mispred_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_lookups_q <= '0;
      stat_hits_q    <= '0;
      stat_mispred_q <= '0;
    end else begin
      if (!sweep_active)           stat_lookups_q <= stat_lookups_q + 32'd1;
      if (lk_hit && !sweep_active) stat_hits_q    <= stat_hits_q + 32'd1;
      if (upd_valid && upd_mispredict) stat_mispred_q <= stat_mispred_q + 32'd1;
    end
  end

  assign stat_lookups = stat_lookups_q;
  assign stat_hits    = stat_hits_q;
  assign stat_mispred = stat_mispred_q;

  logic unused_ok;
  assign unused_ok = ^{lookup_pc[1:0], upd_pc[1:0]};
`else
  logic unused_ok;
  assign unused_ok = ^{upd_mispredict, lookup_pc[1:0], upd_pc[1:0]};
`endif

endmodule

`default_nettype wire

// File: tb/tb_btb_predictor.sv
// ============================================================================
//  Module      : tb_btb_predictor
//  Description : Directed self-checking bench for btb_predictor.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_btb_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        upd_mispredict;
  logic        flush_req;
  logic        busy;
`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups, stat_hits, stat_mispred;
`endif

  int n_checks = 0;
  int n_errors = 0;

  btb_predictor #(.ENTRIES(16)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .lookup_pc      (lookup_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_target     (upd_target),
    .upd_taken      (upd_taken),
    .upd_mispredict (upd_mispredict),
    .flush_req      (flush_req),
    .busy           (busy)
`ifdef BTB_STATS_EN
    ,
    .stat_lookups   (stat_lookups),
    .stat_hits      (stat_hits),
    .stat_mispred   (stat_mispred)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_target = tgt;
    upd_taken  = tk;
    tick();
    upd_valid  = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic exp_tk, input logic [31:0] exp_tg);
    lookup_pc = pc;
    #1;
    check({tag, "_taken"}, {31'h0, pred_taken}, {31'h0, exp_tk});
    check({tag, "_target"}, pred_target, exp_tg);
  endtask

  int busy_cnt;
  logic leak;

  initial begin
    rst = 1'b1; lookup_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_target = '0;
    upd_taken = 1'b0; upd_mispredict = 1'b0; flush_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    look("reset", 32'h100, 1'b0, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);

    // Allocate, then train down with saturation at 00
    upd(32'h100, 32'h200, 1'b1);  look("alloc", 32'h100, 1'b1, 32'h200);
    upd(32'h100, 32'h0, 1'b0);    look("dec_01", 32'h100, 1'b0, 32'h200);
    upd(32'h100, 32'h0, 1'b0);    look("dec_00", 32'h100, 1'b0, 32'h200);
    upd(32'h100, 32'h0, 1'b0);    look("sat_00", 32'h100, 1'b0, 32'h200);

    // Train up with saturation at 11
    upd(32'h100, 32'h204, 1'b1);  look("inc_01", 32'h100, 1'b0, 32'h204);
    upd(32'h100, 32'h208, 1'b1);  look("inc_10", 32'h100, 1'b1, 32'h208);
    upd(32'h100, 32'h20C, 1'b1);  look("inc_11", 32'h100, 1'b1, 32'h20C);
    upd(32'h100, 32'h210, 1'b1);  look("sat_11", 32'h100, 1'b1, 32'h210);
    upd(32'h100, 32'h0, 1'b0);    look("dec_10", 32'h100, 1'b1, 32'h210);
    upd(32'h100, 32'h0, 1'b0);    look("dec_01b", 32'h100, 1'b0, 32'h210);

    // Alias replacement and ignored low PC bits
    upd(32'h140, 32'h500, 1'b1);
    look("alias_new", 32'h140, 1'b1, 32'h500);
    look("alias_old", 32'h100, 1'b0, 32'h0);
    look("low_bits", 32'h143, 1'b1, 32'h500);
    upd(32'h184, 32'h600, 1'b0);
    look("miss_nt", 32'h184, 1'b0, 32'h0);

    // Sweep: simultaneous update dropped, updates and flushes while busy dropped
    upd(32'h108, 32'h700, 1'b1);
    look("pre_flush", 32'h108, 1'b1, 32'h700);
    flush_req = 1'b1; upd_valid = 1'b1; upd_pc = 32'h10C; upd_target = 32'h710; upd_taken = 1'b1;
    tick();
    flush_req = 1'b0; upd_valid = 1'b0;
    check("busy_start", {31'h0, busy}, 32'h1);
    busy_cnt = 0; leak = 1'b0;
    for (int i = 0; i < 40 && busy; i++) begin
      lookup_pc = 32'h108;
      #1;
      if (pred_taken) leak = 1'b1;
      busy_cnt++;
      upd_valid = (i == 3);
      upd_pc = 32'h110; upd_target = 32'h720; upd_taken = 1'b1;
      flush_req = (i == 5);
      @(posedge clk);
      #1;
    end
    upd_valid = 1'b0; flush_req = 1'b0;
    check("busy_cycles", busy_cnt, 32'd16);
    check("sweep_leak", {31'h0, leak}, 32'h0);
    look("swept_108", 32'h108, 1'b0, 32'h0);
    look("swept_10C", 32'h10C, 1'b0, 32'h0);
    look("swept_110", 32'h110, 1'b0, 32'h0);
    look("swept_140", 32'h140, 1'b0, 32'h0);
    tick();

    // Same-cycle lookup and update: no bypass
    lookup_pc = 32'h300;
    upd_valid = 1'b1; upd_pc = 32'h300; upd_target = 32'h600; upd_taken = 1'b1;
    #1;
    check("nobyp_taken", {31'h0, pred_taken}, 32'h0);
    check("nobyp_target", pred_target, 32'h0);
    tick();
    upd_valid = 1'b0;
    look("byp_next", 32'h300, 1'b1, 32'h600);

    // Reset in the middle of a sweep
    upd(32'h13C, 32'h800, 1'b1);
    look("pre_rst", 32'h13C, 1'b1, 32'h800);
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    repeat (4) tick();
    check("mid_busy", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    check("rst_busy", {31'h0, busy}, 32'h0);
    look("rst_miss", 32'h13C, 1'b0, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    check("rst_idle", {31'h0, busy}, 32'h0);
    upd(32'h300, 32'h900, 1'b1);
    look("post_rst", 32'h300, 1'b1, 32'h900);

`ifdef BTB_STATS_EN
    rst = 1'b1; tick(); rst = 1'b0;
    lookup_pc = 32'h100;
    upd_valid = 1'b1; upd_pc = 32'h100; upd_target = 32'h200; upd_taken = 1'b1; upd_mispredict = 1'b1;
    tick();
    upd_valid = 1'b0; upd_mispredict = 1'b0;
    tick(); tick();
    upd_valid = 1'b1; upd_mispredict = 1'b1;
    tick();
    upd_valid = 1'b0; lookup_pc = 32'h900;
    tick();
    upd_mispredict = 1'b0;
    repeat (5) tick();
    check("stat_lookups", stat_lookups, 32'd10);
    check("stat_hits", stat_hits, 32'd3);
    check("stat_mispred", stat_mispred, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
